// File: rtl/tinyproc_run_ctrl_if.sv
// Host/core-facing bundle of the run controller: host command port, core
// enable/reset, instruction-memory write port and status outputs.
interface tinyproc_run_ctrl_if #(
  parameter int IW = 10,
  parameter int AW = 8,
  parameter int CW = 16
);
  // Commands have no backpressure: every cycle with cmd_valid=1 at the rising
  // edge delivers exactly one command; rejects are signalled a cycle later on cmd_err.
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [IW-1:0] cmd_data;
  logic          cmd_err;
  logic [AW-1:0] core_ip;
  logic          core_run;
  logic          core_reset;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [IW-1:0] imem_wdata;
  logic [1:0]    state;
  logic [1:0]    halt_reason;
  logic [CW-1:0] cycle_count;

  modport master (
    output cmd_valid, cmd_op, cmd_data, core_ip,
    input  cmd_err, core_run, core_reset, imem_we, imem_waddr, imem_wdata,
           state, halt_reason, cycle_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, core_ip,
    output cmd_err, core_run, core_reset, imem_we, imem_waddr, imem_wdata,
           state, halt_reason, cycle_count
  );
endinterface

// File: rtl/tinyproc_run_ctrl.sv
// Run controller for the 10-bit accumulator core: loads instruction memory and
// gates the core clock-enable for run, N-step, breakpoint and cycle-budget halts.
module tinyproc_run_ctrl #(
  parameter int IW = 10,
  parameter int AW = 8,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  tinyproc_run_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    HR_HOST      = 2'd0,
    HR_BREAK     = 2'd1,
    HR_STEP_DONE = 2'd2,
    HR_LIMIT     = 2'd3
  } reason_e;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_SET_ADDR   = 3'd1;
  localparam logic [2:0] OP_LOAD_WORD  = 3'd2;
  localparam logic [2:0] OP_RUN        = 3'd3;
  localparam logic [2:0] OP_STEP       = 3'd4;
  localparam logic [2:0] OP_HALT       = 3'd5;
  localparam logic [2:0] OP_SET_BREAK  = 3'd6;
  localparam logic [2:0] OP_RESET_CORE = 3'd7;

  state_e        state_q, state_d;
  reason_e       reason_q, reason_d;
  logic [AW-1:0] load_ptr_q, load_ptr_d;
  logic          bp_en_q, bp_en_d;
  logic [AW-1:0] bp_addr_q, bp_addr_d;
  logic [AW-1:0] step_left_q, step_left_d;
  logic [CW-1:0] cycle_count_q, cycle_count_d;
  logic          first_run_q, first_run_d;
  logic          imem_we_q, imem_we_d;
  logic [AW-1:0] imem_waddr_q, imem_waddr_d;
  logic [IW-1:0] imem_wdata_q, imem_wdata_d;
  logic          core_reset_q, core_reset_d;
  logic          cmd_err_q, cmd_err_d;

  logic limit_hit;
  logic bp_hit;
  logic core_run_c;
  logic cmd_halt;
  logic cmd_reject;

  // The first RUN cycle skips the breakpoint so a resume executes the
  // instruction that caused the previous break.
  assign limit_hit = (cycle_count_q == {CW{1'b1}});
  assign bp_hit    = bp_en_q && (bus.core_ip == bp_addr_q) && !first_run_q;

  always_comb begin
    core_run_c = 1'b0;
    case (state_q)
      ST_RUN:  core_run_c = !bp_hit && !limit_hit;
      ST_STEP: core_run_c = !limit_hit;
      default: core_run_c = 1'b0;
    endcase
  end

  assign cmd_halt   = bus.cmd_valid && (bus.cmd_op == OP_HALT);
  assign cmd_reject = bus.cmd_valid && (bus.cmd_op != OP_NOP) && (bus.cmd_op != OP_HALT);

  always_comb begin
    state_d       = state_q;
    reason_d      = reason_q;
    load_ptr_d    = load_ptr_q;
    bp_en_d       = bp_en_q;
    bp_addr_d     = bp_addr_q;
    step_left_d   = step_left_q;
    cycle_count_d = cycle_count_q;
    first_run_d   = 1'b0;
    imem_we_d     = 1'b0;
    imem_waddr_d  = imem_waddr_q;
    imem_wdata_d  = imem_wdata_q;
    core_reset_d  = 1'b0;
    cmd_err_d     = 1'b0;

    // core_run is never high at saturation, so a plain increment cannot wrap.
    if (core_run_c) begin
      cycle_count_d = cycle_count_q + CW'(1);
    end

    case (state_q)
      ST_HALTED: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_SET_ADDR: load_ptr_d = bus.cmd_data[AW-1:0];
            OP_LOAD_WORD: begin
              imem_we_d    = 1'b1;
              imem_waddr_d = load_ptr_q;
              imem_wdata_d = bus.cmd_data;
              load_ptr_d   = load_ptr_q + AW'(1);
            end
            OP_RUN: begin
              state_d     = ST_RUN;
              first_run_d = 1'b1;
            end
            OP_STEP: begin
              if (bus.cmd_data[AW-1:0] != '0) begin
                step_left_d = bus.cmd_data[AW-1:0];
                state_d     = ST_STEP;
              end
            end
            OP_SET_BREAK: begin
              bp_addr_d = bus.cmd_data[AW-1:0];
              bp_en_d   = bus.cmd_data[AW];
            end
            OP_RESET_CORE: begin
              core_reset_d  = 1'b1;
              cycle_count_d = '0;
            end
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        if (bp_hit) begin
          state_d  = ST_HALTED;
          reason_d = HR_BREAK;
        end else if (limit_hit) begin
          state_d  = ST_HALTED;
          reason_d = HR_LIMIT;
        end else if (cmd_halt) begin
          state_d  = ST_HALTED;
          reason_d = HR_HOST;
        end
        cmd_err_d = cmd_reject;
      end

      ST_STEP: begin
        if (core_run_c) begin
          step_left_d = step_left_q - AW'(1);
        end
        if (limit_hit) begin
          state_d  = ST_HALTED;
          reason_d = HR_LIMIT;
        end else if (cmd_halt) begin
          state_d  = ST_HALTED;
          reason_d = HR_HOST;
        end else if (step_left_q == AW'(1)) begin
          state_d  = ST_HALTED;
          reason_d = HR_STEP_DONE;
        end
        cmd_err_d = cmd_reject;
      end

      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_HALTED;
      reason_q      <= HR_HOST;
      load_ptr_q    <= '0;
      bp_en_q       <= 1'b0;
      bp_addr_q     <= '0;
      step_left_q   <= '0;
      cycle_count_q <= '0;
      first_run_q   <= 1'b0;
      imem_we_q     <= 1'b0;
      imem_waddr_q  <= '0;
      imem_wdata_q  <= '0;
      core_reset_q  <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      reason_q      <= reason_d;
      load_ptr_q    <= load_ptr_d;
      bp_en_q       <= bp_en_d;
      bp_addr_q     <= bp_addr_d;
      step_left_q   <= step_left_d;
      cycle_count_q <= cycle_count_d;
      first_run_q   <= first_run_d;
      imem_we_q     <= imem_we_d;
      imem_waddr_q  <= imem_waddr_d;
      imem_wdata_q  <= imem_wdata_d;
      core_reset_q  <= core_reset_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign bus.core_run    = core_run_c;
  assign bus.core_reset  = core_reset_q;
  assign bus.cmd_err     = cmd_err_q;
  assign bus.imem_we     = imem_we_q;
  assign bus.imem_waddr  = imem_waddr_q;
  assign bus.imem_wdata  = imem_wdata_q;
  assign bus.state       = state_q;
  assign bus.halt_reason = reason_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_tinyproc_run_ctrl.sv
// Directed-plus-random bench for tinyproc_run_ctrl with a straight-line core
// model and an expected-write queue for the instruction memory port.
module tb_tinyproc_run_ctrl;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_SET_ADDR   = 3'd1;
  localparam logic [2:0] OP_LOAD_WORD  = 3'd2;
  localparam logic [2:0] OP_RUN        = 3'd3;
  localparam logic [2:0] OP_STEP       = 3'd4;
  localparam logic [2:0] OP_HALT       = 3'd5;
  localparam logic [2:0] OP_SET_BREAK  = 3'd6;
  localparam logic [2:0] OP_RESET_CORE = 3'd7;

  logic clk;
  logic reset_n;

  tinyproc_run_ctrl_if #(.IW(10), .AW(8), .CW(16)) bus ();

  tinyproc_run_ctrl #(.IW(10), .AW(8), .CW(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [17:0] exp_q[$];
  logic [7:0]  ptr_model;
  int          cnt_model;
  int          run_cnt;
  logic        err_exp;
  logic        rst_exp;
  int          n_pass;
  int          n_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: sample at negedge, advance the core model just after posedge.
  task automatic tick();
    logic run_obs;
    logic rst_obs;
    logic [17:0] e;
    @(negedge clk);
    run_obs = bus.core_run;
    rst_obs = bus.core_reset;
    if (run_obs) run_cnt++;
    if (bus.imem_we || exp_q.size() != 0) begin
      check("imem_we", {31'd0, bus.imem_we}, {31'd0, exp_q.size() != 0});
      if (bus.imem_we && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("imem_write", {14'd0, bus.imem_waddr, bus.imem_wdata}, {14'd0, e});
      end
    end
    if (bus.cmd_err || err_exp) check("cmd_err", {31'd0, bus.cmd_err}, {31'd0, err_exp});
    if (bus.core_reset || rst_exp) check("core_reset", {31'd0, bus.core_reset}, {31'd0, rst_exp});
    err_exp = 1'b0;
    rst_exp = 1'b0;
    @(posedge clk);
    #1;
    if (rst_obs) bus.core_ip = 8'd0;
    else if (run_obs) bus.core_ip = bus.core_ip + 8'd1;
  endtask

  // driver tasks
  task automatic send(input logic [2:0] op, input logic [9:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = '0;
  endtask

  task automatic load_word(input logic [9:0] data);
    send(OP_LOAD_WORD, data);
    exp_q.push_back({ptr_model, data});
    ptr_model = ptr_model + 8'd1;
  endtask

  task automatic set_addr(input logic [7:0] a);
    send(OP_SET_ADDR, {2'b00, a});
    ptr_model = a;
  endtask

  task automatic reset_core();
    send(OP_RESET_CORE, '0);
    rst_exp   = 1'b1;
    cnt_model = 0;
    check("count_after_reset_core", {16'd0, bus.cycle_count}, 32'd0);
    tick();
  endtask

  task automatic wait_halt(input int max_cycles);
    int n;
    n = 0;
    while (bus.state != 2'd0 && n < max_cycles) begin
      tick();
      n++;
    end
    check("halt_timeout", {30'd0, bus.state}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_run"},    {31'd0, bus.core_run}, 32'd0);
    check({tag, "_state"},       {30'd0, bus.state}, 32'd0);
    check({tag, "_halt_reason"}, {30'd0, bus.halt_reason}, 32'd0);
    check({tag, "_cycle_count"}, {16'd0, bus.cycle_count}, 32'd0);
    check({tag, "_imem_we"},     {31'd0, bus.imem_we}, 32'd0);
    check({tag, "_core_reset"},  {31'd0, bus.core_reset}, 32'd0);
    check({tag, "_cmd_err"},     {31'd0, bus.cmd_err}, 32'd0);
  endtask

  initial begin
    int n;
    int b;
    int k;
    n_pass    = 0;
    n_total   = 0;
    ptr_model = 8'd0;
    cnt_model = 0;
    run_cnt   = 0;
    err_exp   = 1'b0;
    rst_exp   = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_data  = '0;
    bus.core_ip   = 8'd0;
    reset_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;

    // program load, including pointer wrap
    set_addr(8'h10);
    load_word(10'h005);
    load_word(10'h110);
    load_word(10'h200);
    load_word(10'h3C3);
    set_addr(8'hFF);
    load_word(10'($urandom_range(0, 1023)));
    load_word(10'($urandom_range(0, 1023)));
    repeat (3) begin
      set_addr(8'($urandom_range(0, 255)));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) load_word(10'($urandom_range(0, 1023)));
    end
    tick();
    check("load_queue_drained", exp_q.size(), 32'd0);

    // stepping
    reset_core();
    run_cnt = 0;
    send(OP_STEP, 10'd3);
    wait_halt(50);
    check("step3_runs", run_cnt, 32'd3);
    check("step3_reason", {30'd0, bus.halt_reason}, 32'd2);
    check("step3_count", {16'd0, bus.cycle_count}, 32'd3);
    cnt_model = 3;
    run_cnt = 0;
    send(OP_STEP, 10'd0);
    repeat (3) tick();
    check("step0_runs", run_cnt, 32'd0);
    check("step0_state", {30'd0, bus.state}, 32'd0);
    repeat (3) begin
      n = $urandom_range(1, 40);
      run_cnt = 0;
      send(OP_STEP, 10'(n));
      wait_halt(60);
      cnt_model += n;
      check("rstep_runs", run_cnt, n);
      check("rstep_reason", {30'd0, bus.halt_reason}, 32'd2);
      check("rstep_count", {16'd0, bus.cycle_count}, cnt_model);
    end

    // breakpoint then resume and host halt
    send(OP_SET_BREAK, 10'h105);
    reset_core();
    run_cnt = 0;
    send(OP_RUN, '0);
    wait_halt(50);
    check("bp_runs", run_cnt, 32'd5);
    check("bp_reason", {30'd0, bus.halt_reason}, 32'd1);
    check("bp_count", {16'd0, bus.cycle_count}, 32'd5);
    cnt_model = 5;
    run_cnt = 0;
    send(OP_RUN, '0);
    k = $urandom_range(2, 8);
    repeat (k) tick();
    check("resume_running", {30'd0, bus.state}, 32'd1);
    send(OP_HALT, '0);
    cnt_model += k + 1;
    check("host_halt_runs", run_cnt, k + 1);
    check("host_halt_state", {30'd0, bus.state}, 32'd0);
    check("host_halt_reason", {30'd0, bus.halt_reason}, 32'd0);
    check("host_halt_count", {16'd0, bus.cycle_count}, cnt_model);

    // random breakpoint address
    b = $urandom_range(10, 60);
    send(OP_SET_BREAK, 10'h100 | 10'(b));
    reset_core();
    run_cnt = 0;
    send(OP_RUN, '0);
    wait_halt(100);
    check("rbp_runs", run_cnt, b);
    check("rbp_reason", {30'd0, bus.halt_reason}, 32'd1);
    check("rbp_count", {16'd0, bus.cycle_count}, b);

    // breakpoint and HALT in the same cycle: BREAK wins
    send(OP_SET_BREAK, 10'h103);
    reset_core();
    run_cnt = 0;
    send(OP_RUN, '0);
    repeat (3) tick();
    send(OP_HALT, '0);
    check("bp_vs_halt_runs", run_cnt, 32'd3);
    check("bp_vs_halt_reason", {30'd0, bus.halt_reason}, 32'd1);

    // rejected commands while running
    send(OP_SET_BREAK, 10'h000);
    send(OP_RUN, '0);
    tick();
    send(OP_LOAD_WORD, 10'h3AA);
    err_exp = 1'b1;
    send(OP_SET_ADDR, 10'h077);
    err_exp = 1'b1;
    send(OP_NOP, '0);
    send(OP_HALT, '0);
    tick();
    check("reject_halt_state", {30'd0, bus.state}, 32'd0);
    check("reject_halt_reason", {30'd0, bus.halt_reason}, 32'd0);
    load_word(10'h155);
    tick();
    check("ptr_unchanged_queue", exp_q.size(), 32'd0);

    // cycle budget
    reset_core();
    run_cnt = 0;
    send(OP_RUN, '0);
    wait_halt(70000);
    check("limit_runs", run_cnt, 32'd65535);
    check("limit_reason", {30'd0, bus.halt_reason}, 32'd3);
    check("limit_count", {16'd0, bus.cycle_count}, 32'hFFFF);
    run_cnt = 0;
    send(OP_STEP, 10'd5);
    wait_halt(20);
    send(OP_RUN, '0);
    wait_halt(20);
    check("limit_stuck_runs", run_cnt, 32'd0);
    check("limit_stuck_reason", {30'd0, bus.halt_reason}, 32'd3);
    reset_core();
    run_cnt = 0;
    send(OP_STEP, 10'd2);
    wait_halt(20);
    check("after_limit_runs", run_cnt, 32'd2);
    check("after_limit_reason", {30'd0, bus.halt_reason}, 32'd2);

    // asynchronous reset in the middle of RUN
    send(OP_SET_BREAK, 10'h128);
    reset_core();
    send(OP_RUN, '0);
    repeat (10) tick();
    #1 reset_n = 1'b0;
    #1;
    check_reset_values("midrun");
    bus.core_ip = 8'd0;
    ptr_model   = 8'd0;
    #1 reset_n = 1'b1;
    run_cnt = 0;
    send(OP_RUN, '0);
    repeat (60) tick();
    check("bp_cleared_state", {30'd0, bus.state}, 32'd1);
    check("bp_cleared_runs", run_cnt, 32'd60);
    send(OP_HALT, '0);
    load_word(10'h2F0);
    tick();
    check("ptr_reset_queue", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tinyproc_run_ctrl.md
Name: tinyproc_run_ctrl

Overview:
Host-side controller for the 10-bit-instruction accumulator core. It loads instruction memory through the core's imem write port and sequences execution through a clock-enable: run, halt, N-step, breakpoint on instruction pointer, and a cycle-budget limit. A host command port drives it, and it reports status back. It sits between the host/debug bus and the core; the core only advances when core_run is high.

Parameters:
IW, 10, instruction word width (2-bit opcode + 8-bit operand)
AW, 8, instruction address / pointer width
CW, 16, cycle counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command strobe, one command per cycle
cmd_op  in  3  0 NOP, 1 SET_ADDR, 2 LOAD_WORD, 3 RUN, 4 STEP, 5 HALT, 6 SET_BREAK, 7 RESET_CORE
cmd_data  in  IW  command operand
cmd_err  out  1  one-cycle pulse: command rejected in the current state
core_ip  in  AW  core instruction pointer (address of the instruction executing this cycle)
core_run  out  1  core clock-enable
core_reset  out  1  one-cycle sync clear pulse to the core (ip and accumulator to 0)
imem_we  out  1  instruction memory write strobe
imem_waddr  out  AW  write address
imem_wdata  out  IW  write data
state  out  2  0 HALTED, 1 RUN, 2 STEP
halt_reason  out  2  0 HOST, 1 BREAK, 2 STEP_DONE, 3 LIMIT
cycle_count  out  CW  number of core_run-high cycles since the last RESET_CORE; saturating

Behaviour:
- Reset (async, reset_n low) takes effect immediately, including mid-RUN, with core_run low at once:
  - state HALTED, halt_reason HOST;
  - load_ptr 0, bp_en 0, bp_addr 0, step_left 0, cycle_count 0;
  - imem_we, core_reset and cmd_err all 0.
- All outputs are registered except core_run, which is combinational from state, core_ip and the breakpoint registers.
- Commands are sampled on the rising edge when cmd_valid=1. There is no backpressure.
- Commands in HALTED:
  - SET_ADDR: load_ptr <= cmd_data[7:0].
  - LOAD_WORD: next cycle imem_we=1 for one cycle, with imem_waddr=load_ptr and imem_wdata=cmd_data. load_ptr then increments and wraps 255->0. Back-to-back LOAD_WORDs give one write per cycle.
  - RUN: state RUN next cycle.
  - STEP: N=cmd_data[7:0]. If N=0 it is a no-op and the state stays HALTED with no cmd_err. Otherwise step_left <= N and state STEP.
  - SET_BREAK: bp_addr <= cmd_data[7:0], bp_en <= cmd_data[8].
  - RESET_CORE: next cycle core_reset=1 for one cycle, and cycle_count <= 0.
  - HALT and NOP: no effect.
- Commands in RUN/STEP:
  - HALT: state HALTED next cycle with halt_reason HOST. The core still executes during the accept cycle.
  - NOP: ignored.
  - Any other op: ignored, and cmd_err pulses next cycle.
- RUN, per cycle:
  - bp_hit = bp_en & (core_ip==bp_addr) & !first_run_cycle.
  - first_run_cycle is 1 only on the first cycle after entering RUN, so resuming from a breakpoint executes that instruction.
  - core_run = !bp_hit.
  - On bp_hit: state HALTED, halt_reason BREAK. The instruction at bp_addr has not executed.
- STEP, per cycle:
  - core_run=1 and step_left decrements.
  - When step_left==1 this cycle, the state becomes HALTED next cycle with halt_reason STEP_DONE.
  - Breakpoints are not checked in STEP.
- Cycle limit:
  - cycle_count increments on every core_run=1 cycle.
  - When it holds all-ones in RUN or STEP, core_run=0 and the state goes HALTED with halt_reason LIMIT.
  - Further RUN/STEP commands halt again immediately with LIMIT until RESET_CORE.
- Priority within a cycle: async reset > bp_hit/LIMIT (core not enabled) > HALT command > STEP completion.
  - If bp_hit and HALT coincide, halt_reason is BREAK.
  - If LIMIT and bp_hit coincide, halt_reason is BREAK.
- halt_reason holds its value until the next halt event.

Test Plan:
- Load program: SET_ADDR 0x10, then LOAD_WORD 0x005, 0x110, 0x200 back-to-back -> three consecutive imem_we pulses at addresses 0x10, 0x11, 0x12 with matching data; load_ptr ends at 0x13. SET_ADDR 0xFF followed by 2 LOAD_WORDs -> writes at 0xFF, then 0x00.
- STEP 3 from HALTED -> core_run high for exactly 3 cycles, then state HALTED with halt_reason STEP_DONE and cycle_count 3. STEP 0 -> no core_run, no cmd_err.
- SET_BREAK 0x105 (enabled, address 0x05), RESET_CORE, RUN on a straight-line program -> core_run low in the cycle core_ip=0x05; HALTED with halt_reason BREAK; cycle_count 5. Second RUN -> instruction 0x05 executes and the core continues.
- RUN, then HALT accepted at cycle k -> core_run high through the accept cycle, HALTED next cycle with halt_reason HOST. LOAD_WORD issued during RUN -> cmd_err pulse, no imem_we.
- Cycle limit: force cycle_count to 0xFFFE, RUN -> one more enabled cycle, then halt_reason LIMIT and core_run stuck low. RESET_CORE -> count 0 and core_reset pulses for one cycle.
- Assert reset_n low mid-RUN -> core_run drops asynchronously; all registers return to reset values; bp_en cleared.
